// File: rtl/ssd_instr_batcher.sv
// Packs incoming SSD instructions into fixed-size batches on an AXI-stream:
// one instruction per beat, zero padding, then a trailer beat carrying tlast.
module ssd_instr_batcher #(
  parameter int unsigned MAX_BEATS      = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned DATA_BITS      = 512,
  parameter int unsigned INSTR_BITS     = 418
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [INSTR_BITS-1:0] instr_in,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic                  flush,
  output logic [DATA_BITS-1:0]  m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [31:0]           batch_count,
  output logic                  busy
);

  localparam int unsigned BW = $clog2(MAX_BEATS + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BW-1:0] LastIdx  = BW'(MAX_BEATS - 1);
  localparam logic [TW-1:0] TimerMax = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]   Magic    = 32'h5D1E_7A11;

  typedef enum logic [1:0] {StIdle, StFill, StPad, StTrail} state_e;

  state_e               state_q, state_d;
  logic [BW-1:0]        beat_idx_q, beat_idx_d;
  logic [BW-1:0]        cnt_q, cnt_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [31:0]          seq_q, seq_d;
  logic [31:0]          bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] tdata_q, tdata_d;
  logic                 tvalid_q, tvalid_d;
  logic                 tlast_q, tlast_d;

  logic                 load_ok;
  logic                 accept;
  logic [DATA_BITS-1:0] instr_beat;
  logic [DATA_BITS-1:0] trailer_beat;

  // Handshake qualifiers and the two non-trivial beat formats.
  always_comb begin
    load_ok     = !tvalid_q || m_axis_tready;
    // Gated by aresetn so nothing is accepted while reset is held.
    instr_ready = aresetn && ((state_q == StIdle) || (state_q == StFill)) && load_ok &&
                  (beat_idx_q < LastIdx);
    accept      = instr_valid && instr_ready;
    instr_beat  = '0;
    instr_beat[INSTR_BITS-1:0] = instr_in;
    trailer_beat = '0;
    trailer_beat[15:0]  = 16'(cnt_q);
    trailer_beat[47:16] = seq_q;
    trailer_beat[DATA_BITS-1 -: 32] = Magic;
  end

  // Next-state logic for the batch FSM and the single output register.
  always_comb begin
    state_d    = state_q;
    beat_idx_d = beat_idx_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    seq_d      = seq_q;
    bcnt_d     = bcnt_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end
    unique case (state_q)
      StIdle, StFill: begin
        if (accept) begin
          tdata_d    = instr_beat;
          tvalid_d   = 1'b1;
          tlast_d    = 1'b0;
          beat_idx_d = beat_idx_q + BW'(1);
          cnt_d      = cnt_q + BW'(1);
          timer_d    = '0;
          // A full batch needs no padding even if flush coincides.
          if (beat_idx_d == LastIdx) begin
            state_d = StTrail;
          end else if (flush && (state_q == StFill)) begin
            state_d = StPad;
          end else begin
            state_d = StFill;
          end
        end else if (state_q == StFill) begin
          timer_d = timer_q + TW'(1);
          if (flush || (timer_q == TimerMax)) begin
            state_d = StPad;
            timer_d = '0;
          end
        end
      end
      StPad: begin
        if (load_ok) begin
          tdata_d    = '0;
          tvalid_d   = 1'b1;
          tlast_d    = 1'b0;
          beat_idx_d = beat_idx_q + BW'(1);
          if (beat_idx_d == LastIdx) state_d = StTrail;
        end
      end
      StTrail: begin
        // tlast in the register marks the trailer as already loaded.
        if (tvalid_q && tlast_q) begin
          if (m_axis_tready) begin
            state_d    = StIdle;
            beat_idx_d = '0;
            cnt_d      = '0;
            seq_d      = seq_q + 32'd1;
            bcnt_d     = bcnt_q + 32'd1;
          end
        end else if (load_ok) begin
          tdata_d  = trailer_beat;
          tvalid_d = 1'b1;
          tlast_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset drops any partial batch.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= StIdle;
      beat_idx_q <= '0;
      cnt_q      <= '0;
      timer_q    <= '0;
      seq_q      <= '0;
      bcnt_q     <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_idx_q <= beat_idx_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      seq_q      <= seq_d;
      bcnt_q     <= bcnt_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign batch_count   = bcnt_q;
  assign busy          = (state_q != StIdle) || tvalid_q;

endmodule

// File: tb/tb_ssd_instr_batcher.sv
// Scoreboard bench for ssd_instr_batcher: stimulus pushes expected beats,
// a negedge monitor pops and compares on every output handshake.
module tb_ssd_instr_batcher;

  localparam int DW = 512;
  localparam int IW = 418;
  localparam int MB = 64;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [IW-1:0] instr_in = '0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic          flush = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic [31:0]   batch_count;
  logic          busy;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  beat_t sb[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    beats_seen = 0;
  bit    rand_rdy = 1'b0;
  int    exp_seq = 0;

  ssd_instr_batcher #(
    .MAX_BEATS(MB), .TIMEOUT_CYCLES(1024), .DATA_BITS(DW), .INSTR_BITS(IW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .flush(flush), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .batch_count(batch_count), .busy(busy)
  );

  always #5 aclk = ~aclk;

  // Downstream ready: always 1, or a coin flip per cycle when rand_rdy is set.
  initial forever begin
    @(posedge aclk);
    #1;
    m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: every accepted output beat must match the head of the scoreboard.
  always @(negedge aclk) begin
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      beat_t e;
      beats_seen++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL beat: unexpected beat last=%0b data=%h", m_axis_tlast, m_axis_tdata);
      end else begin
        e = sb.pop_front();
        if (e.data !== m_axis_tdata || e.last !== m_axis_tlast) begin
          n_fail++;
          $display("FAIL beat %0d: got last=%0b data=%h want last=%0b data=%h", beats_seen,
                   m_axis_tlast, m_axis_tdata, e.last, e.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk_instr(input logic [31:0] tag);
    logic [IW-1:0] v;
    v = '0;
    v[IW-1 -: 4] = 4'h1;
    v[31:0]      = tag;
    v[200 +: 32] = ~tag;
    return v;
  endfunction

  function automatic beat_t instr_beat(input logic [IW-1:0] i);
    beat_t b;
    b = '0;
    b.data[IW-1:0] = i;
    return b;
  endfunction

  function automatic beat_t trailer_beat(input int cnt, input int seq);
    beat_t b;
    b = '0;
    b.last = 1'b1;
    b.data[15:0]    = cnt[15:0];
    b.data[47:16]   = seq;
    b.data[511:480] = 32'h5D1E_7A11;
    return b;
  endfunction

  // Present one instruction until accepted; optional flush in the accept cycle.
  task automatic send(input logic [IW-1:0] i, input bit do_flush, output int waits);
    instr_in    = i;
    instr_valid = 1'b1;
    waits       = 0;
    forever begin
      @(negedge aclk);
      if (instr_ready) break;
      waits++;
      if (waits > 5000) begin
        check("send_timeout", 64'(waits), 64'd0);
        instr_valid = 1'b0;
        return;
      end
    end
    if (do_flush) flush = 1'b1;
    @(posedge aclk);
    #1;
    flush = 1'b0;
    sb.push_back(instr_beat(i));
  endtask

  task automatic finish_batch(input int cnt);
    for (int k = 0; k < MB - 1 - cnt; k++) sb.push_back(beat_t'(0));
    sb.push_back(trailer_beat(cnt, exp_seq));
    exp_seq++;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge aclk);
    #1;
    flush = 1'b0;
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while ((sb.size() != 0 || busy) && c < budget) begin
      @(posedge aclk);
      c++;
    end
    #1;
    check("drain_done", 64'(sb.size() == 0 && !busy), 64'd1);
  endtask

  task automatic do_reset();
    aresetn     = 1'b0;
    instr_valid = 1'b0;
    flush       = 1'b0;
    sb.delete();
    exp_seq = 0;
    repeat (2) @(posedge aclk);
    #2;
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_tdata_zero", 64'(m_axis_tdata == '0), 64'd1);
    check("rst_batch_count", 64'(batch_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_instr_ready", 64'(instr_ready), 64'd0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  initial begin
    int w;
    int tot;
    int base;

    // 1: single instruction then flush -> instr, 62 pads, trailer.
    do_reset();
    send(mk_instr(32'h10), 1'b0, w);
    instr_valid = 1'b0;
    finish_batch(1);
    pulse_flush();
    drain(300);
    check("t1_batch_count", 64'(batch_count), 64'd1);

    // 2: 63 back-to-back instructions, no padding.
    do_reset();
    tot = 0;
    for (int k = 0; k < 63; k++) begin
      send(mk_instr(32'h100 + k), 1'b0, w);
      tot += w;
    end
    check("t2_ready_in_trailer", 64'(instr_ready), 64'd0);
    instr_valid = 1'b0;
    finish_batch(63);
    check("t2_no_stalls", 64'(tot), 64'd0);
    drain(300);
    check("t2_batch_count", 64'(batch_count), 64'd1);

    // 3: timeout closes the batch after 1024 idle cycles.
    do_reset();
    base = beats_seen;
    for (int k = 0; k < 3; k++) send(mk_instr(32'h300 + k), 1'b0, w);
    instr_valid = 1'b0;
    finish_batch(3);
    repeat (1015) @(posedge aclk);
    #1;
    check("t3_no_pad_before_timeout", 64'(beats_seen - base), 64'd3);
    drain(2000);
    check("t3_beats_total", 64'(beats_seen - base), 64'd64);
    send(mk_instr(32'h3FF), 1'b0, w);
    instr_valid = 1'b0;
    finish_batch(1);
    pulse_flush();
    drain(300);
    check("t3_batch_count", 64'(batch_count), 64'd2);

    // 4: random backpressure over five full batches.
    do_reset();
    rand_rdy = 1'b1;
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 63; k++) send(mk_instr(32'h1000 * (b + 1) + k), 1'b0, w);
      finish_batch(63);
    end
    instr_valid = 1'b0;
    drain(5000);
    rand_rdy = 1'b0;
    check("t4_batch_count", 64'(batch_count), 64'd5);

    // 5: flush in IDLE does nothing; flush coinciding with an accept keeps it.
    do_reset();
    base = beats_seen;
    pulse_flush();
    repeat (5) @(posedge aclk);
    #1;
    check("t5_idle_flush_busy", 64'(busy), 64'd0);
    check("t5_idle_flush_beats", 64'(beats_seen - base), 64'd0);
    send(mk_instr(32'h507), 1'b0, w);
    send(mk_instr(32'h508), 1'b1, w);
    instr_valid = 1'b0;
    finish_batch(2);
    drain(300);
    check("t5_batch_count", 64'(batch_count), 64'd1);

    // 6: reset mid-PAD clears outputs; next batch restarts at seq 0.
    send(mk_instr(32'h609), 1'b0, w);
    instr_valid = 1'b0;
    finish_batch(1);
    pulse_flush();
    repeat (10) @(posedge aclk);
    #1;
    check("t6_busy_in_pad", 64'(busy), 64'd1);
    @(negedge aclk);
    #2;
    aresetn = 1'b0;
    sb.delete();
    exp_seq = 0;
    #1;
    check("t6_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("t6_rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("t6_rst_tdata_zero", 64'(m_axis_tdata == '0), 64'd1);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_batch_count", 64'(batch_count), 64'd0);
    check("t6_rst_instr_ready", 64'(instr_ready), 64'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    send(mk_instr(32'h60A), 1'b0, w);
    instr_valid = 1'b0;
    finish_batch(1);
    pulse_flush();
    drain(300);
    check("t6_batch_count", 64'(batch_count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
